// File: rtl/chan_pkg.sv
// Shared definitions for the channel arbiter slice.
// Holds the default codeword and counter widths, the arbiter FSM state
// encoding and the codeword type. Bit 0 of a codeword is the leftmost bit.
package chan_pkg;

  localparam int WIDTH = 9;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef logic [0:WIDTH-1] codeword_t;

endpackage

// File: rtl/channel_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant logic.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   valid[1:0] - request lines, valid[n] belongs to requester n
//   accept     - the grant is being consumed this cycle
//   grant      - index of the granted requester (meaningful when any_valid)
//   any_valid  - at least one requester is asking
// The priority bit names the requester that wins a tie. It flips to the
// other requester only when a grant is actually consumed, so a requester
// that withdraws before acceptance does not lose its turn.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic       grant,
  output logic       any_valid
);

  logic prio_reg;

  always_comb begin
    any_valid = valid[0] | valid[1];
    if (valid[0] && valid[1]) begin
      grant = prio_reg;
    end else begin
      grant = valid[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_reg <= 1'b0;
    end else if (accept) begin
      prio_reg <= ~grant;
    end
  end

endmodule

// File: rtl/channel_arbiter.sv
// channel_arbiter: shares one single-bit-error channel between two codeword
// producers.
// Ports:
//   clk, rst                  - clock and synchronous active-high reset
//   req0_valid/data/ready     - requester 0 handshake (ready is combinational)
//   req1_valid/data/ready     - requester 1 handshake (ready is combinational)
//   ch_in                     - registered drive to the channel input
//   ch_out                    - channel output, combinational from ch_in
//   out_valid/data/src/err_mask, out_ready
//                             - captured word, its source and flipped bits
//   cnt0, cnt1                - saturating counts of delivered words
//   busy                      - a word is in flight or awaiting downstream
// Flow: IDLE accepts a word and registers it onto ch_in, SEND gives the
// channel one cycle to settle and captures its output, HOLD presents the
// capture until downstream takes it.
module channel_arbiter #(
  parameter int WIDTH = chan_pkg::WIDTH,
  parameter int CNT_W = chan_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [0:WIDTH-1] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [0:WIDTH-1] req1_data,
  output logic             req1_ready,
  output logic [0:WIDTH-1] ch_in,
  input  logic [0:WIDTH-1] ch_out,
  output logic             out_valid,
  output logic [0:WIDTH-1] out_data,
  output logic             out_src,
  output logic [0:WIDTH-1] out_err_mask,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             busy
);

  import chan_pkg::*;

  state_t           state_reg;
  state_t           state_next;
  logic [0:WIDTH-1] ch_in_reg;
  logic             src_reg;
  logic             out_valid_reg;
  logic [0:WIDTH-1] out_data_reg;
  logic             out_src_reg;
  logic [0:WIDTH-1] out_err_mask_reg;
  logic [CNT_W-1:0] cnt_reg  [2];
  logic [CNT_W-1:0] cnt_next [2];

  logic grant;
  logic any_valid;
  logic accept;
  logic deliver;

  // Requests are only taken in IDLE; rst masks the handshake so nothing is
  // accepted (and priority does not move) while reset is held.
  assign accept  = (state_reg == IDLE) && any_valid && !rst;
  assign deliver = (state_reg == HOLD) && out_ready;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid     ({req1_valid, req0_valid}),
    .accept    (accept),
    .grant     (grant),
    .any_valid (any_valid)
  );

  assign req0_ready = accept && !grant && req0_valid;
  assign req1_ready = accept &&  grant && req1_valid;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)  state_next = SEND;
      SEND:                 state_next = HOLD;
      HOLD:    if (deliver) state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      ch_in_reg        <= '0;
      src_reg          <= 1'b0;
      out_valid_reg    <= 1'b0;
      out_data_reg     <= '0;
      out_src_reg      <= 1'b0;
      out_err_mask_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        ch_in_reg <= grant ? req1_data : req0_data;
        src_reg   <= grant;
      end
      // ch_in has been stable for a full cycle, so ch_out reflects exactly
      // the word in flight; the XOR recovers which bits the channel flipped.
      if (state_reg == SEND) begin
        out_data_reg     <= ch_out;
        out_err_mask_reg <= ch_out ^ ch_in_reg;
        out_src_reg      <= src_reg;
        out_valid_reg    <= 1'b1;
      end
      if (deliver) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  // Per-requester delivered-word counters, saturating at all ones.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    localparam logic IDX = (gi == 1);
    assign cnt_next[gi] = (deliver && out_src_reg == IDX && cnt_reg[gi] != '1)
                          ? cnt_reg[gi] + CNT_W'(1) : cnt_reg[gi];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        cnt_reg[i] <= '0;
      end else begin
        cnt_reg[i] <= cnt_next[i];
      end
    end
  end

  assign ch_in        = ch_in_reg;
  assign out_valid    = out_valid_reg;
  assign out_data     = out_data_reg;
  assign out_src      = out_src_reg;
  assign out_err_mask = out_err_mask_reg;
  assign cnt0         = cnt_reg[0];
  assign cnt1         = cnt_reg[1];
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_channel_arbiter.sv
// Self-checking bench for channel_arbiter. The channel is modelled here as
// ch_out = ch_in ^ chan_mask, where chan_mask has at most one bit set
// (KEY selects the flipped bit index, KEY >= WIDTH means no error).
module tb_channel_arbiter;
  import chan_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  codeword_t   req0_data, req1_data;
  logic        req0_ready, req1_ready;
  codeword_t   ch_in, ch_out, chan_mask;
  logic        out_valid, out_src, out_ready, busy;
  codeword_t   out_data, out_err_mask;
  logic [7:0]  cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ch_out = ch_in ^ chan_mask;

  channel_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .ch_in        (ch_in),
    .ch_out       (ch_out),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_src      (out_src),
    .out_err_mask (out_err_mask),
    .out_ready    (out_ready),
    .cnt0         (cnt0),
    .cnt1         (cnt1),
    .busy         (busy)
  );

  typedef struct {
    int        src;
    codeword_t data;
    int        key;
    codeword_t exp_data;
    codeword_t exp_mask;
    int        exp_cnt0;
    int        exp_cnt1;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_key(input int k);
    chan_mask = '0;
    if (k < WIDTH) chan_mask[k] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // One word through the whole pipeline from an idle arbiter.
  task automatic run_word(input vec_t v, input int idx);
    bit seen;
    int waited;
    seen = 0;
    waited = 0;
    set_key(v.key);
    out_ready = 1'b1;
    if (v.src == 0) begin req0_valid = 1'b1; req0_data = v.data; end
    else            begin req1_valid = 1'b1; req1_data = v.data; end
    for (int c = 0; c < 8 && !seen; c++) begin
      mid();
      if ((v.src == 0) ? req0_ready : req1_ready) seen = 1;
      else waited++;
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk($sformatf("vec%0d accept", idx), 32'(seen), 32'd1);
    chk($sformatf("vec%0d accept_wait", idx), 32'(waited), 32'd0);
    mid();
    chk($sformatf("vec%0d ch_in", idx), 32'(ch_in), 32'(v.data));
    chk($sformatf("vec%0d send_valid", idx), 32'(out_valid), 32'd0);
    step();
    mid();
    chk($sformatf("vec%0d out_valid", idx), 32'(out_valid), 32'd1);
    chk($sformatf("vec%0d out_data", idx), 32'(out_data), 32'(v.exp_data));
    chk($sformatf("vec%0d out_err_mask", idx), 32'(out_err_mask), 32'(v.exp_mask));
    chk($sformatf("vec%0d out_src", idx), 32'(out_src), 32'(v.src));
    step();
    mid();
    chk($sformatf("vec%0d done_valid", idx), 32'(out_valid), 32'd0);
    chk($sformatf("vec%0d cnt0", idx), 32'(cnt0), 32'(v.exp_cnt0));
    chk($sformatf("vec%0d cnt1", idx), 32'(cnt1), 32'(v.exp_cnt1));
    step();
  endtask

  // Reference model state for the random phase.
  bit        m_pending;
  int        m_age;
  bit        m_last;
  bit        m_src;
  int        m_cnt [2];
  codeword_t m_ch_in, m_exp_data, m_exp_mask;

  initial begin
    int order [6];
    int when  [6];
    int n;
    codeword_t x_word;
    codeword_t exp_hold;

    //          src data           key exp_data       exp_mask     c0 c1
    vecs[0] = '{0, 9'b000000000, 7, 9'b000000010, 9'b000000010, 1, 0};
    vecs[1] = '{1, 9'b111111111, 0, 9'b011111111, 9'b100000000, 1, 1};
    vecs[2] = '{0, 9'b101010101, 8, 9'b101010100, 9'b000000001, 2, 1};
    vecs[3] = '{1, 9'b000011110, 4, 9'b000001110, 9'b000010000, 2, 2};
    vecs[4] = '{1, 9'b110000011, 9, 9'b110000011, 9'b000000000, 2, 3};
    vecs[5] = '{0, 9'b011100101, 2, 9'b010100101, 9'b001000000, 3, 3};

    // Reset state; a valid request must not see ready while rst is high.
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    req0_data = 9'b111000111;
    req1_data = '0;
    out_ready = 1'b0;
    chan_mask = '0;
    step();
    mid();
    chk("rst req0_ready", 32'(req0_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ch_in", 32'(ch_in), 32'd0);
    chk("rst out_data", 32'(out_data), 32'd0);
    chk("rst out_src", 32'(out_src), 32'd0);
    chk("rst out_err_mask", 32'(out_err_mask), 32'd0);
    chk("rst cnt0", 32'(cnt0), 32'd0);
    chk("rst cnt1", 32'(cnt1), 32'd0);
    step();
    rst = 1'b0;
    req0_valid = 1'b0;

    for (int i = 0; i < 6; i++) run_word(vecs[i], i);

    // Both requesters valid continuously: strict alternation, 3 cycles apart.
    do_reset();
    set_key(9);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
      req0_data = codeword_t'($urandom);
      req1_data = codeword_t'($urandom);
      mid();
      chk("alt onehot", 32'(req0_ready & req1_ready), 32'd0);
      if (req0_ready || req1_ready) begin
        order[n] = int'(req1_ready);
        when[n] = cyc;
        n++;
      end
      step();
      if (n == 6) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    chk("alt accepts", 32'(n), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("alt grant%0d", i), 32'(order[i]), 32'(i % 2));
      if (i > 0) chk($sformatf("alt spacing%0d", i), 32'(when[i] - when[i-1]), 32'd3);
    end
    step();
    step();
    step();
    mid();
    chk("alt cnt0", 32'(cnt0), 32'd3);
    chk("alt cnt1", 32'(cnt1), 32'd3);
    step();

    // Downstream stall in HOLD with req1 pending.
    x_word = 9'b100110011;
    set_key(3);
    exp_hold = 9'b100010011;
    out_ready = 1'b0;
    req0_valid = 1'b1;
    req0_data = x_word;
    mid();
    chk("stall req0_ready", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_data = 9'b010101010;
    mid();
    chk("stall send req1_ready", 32'(req1_ready), 32'd0);
    step();
    for (int i = 0; i < 6; i++) begin
      mid();
      chk($sformatf("stall%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d out_data", i), 32'(out_data), 32'(exp_hold));
      chk($sformatf("stall%0d out_src", i), 32'(out_src), 32'd0);
      chk($sformatf("stall%0d out_err_mask", i), 32'(out_err_mask), 32'(9'b000100000));
      chk($sformatf("stall%0d req1_ready", i), 32'(req1_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    mid();
    chk("stall release req1_ready", 32'(req1_ready), 32'd0);
    chk("stall release out_valid", 32'(out_valid), 32'd1);
    step();
    mid();
    chk("stall idle out_valid", 32'(out_valid), 32'd0);
    chk("stall idle req1_ready", 32'(req1_ready), 32'd1);
    chk("stall idle cnt0", 32'(cnt0), 32'd4);
    step();
    req1_valid = 1'b0;
    step();
    step();
    mid();
    chk("stall cnt1", 32'(cnt1), 32'd4);
    step();

    // Lone req1 with prio 0 wins at once; then reset in SEND.
    do_reset();
    set_key(9);
    out_ready = 1'b1;
    req1_valid = 1'b1;
    req1_data = 9'b000111000;
    mid();
    chk("lone req1_ready", 32'(req1_ready), 32'd1);
    chk("lone req0_ready", 32'(req0_ready), 32'd0);
    step();
    req1_valid = 1'b0;
    step();
    step();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    mid();
    chk("after lone prio req0_ready", 32'(req0_ready), 32'd1);
    chk("after lone cnt1", 32'(cnt1), 32'd1);
    step();
    rst = 1'b1;
    mid();
    chk("rst send busy_before", 32'(busy), 32'd1);
    chk("rst held req0_ready", 32'(req0_ready), 32'd0);
    chk("rst held req1_ready", 32'(req1_ready), 32'd0);
    step();
    rst = 1'b0;
    mid();
    chk("rst send out_valid", 32'(out_valid), 32'd0);
    chk("rst send busy", 32'(busy), 32'd0);
    chk("rst send cnt0", 32'(cnt0), 32'd0);
    chk("rst send cnt1", 32'(cnt1), 32'd0);
    chk("rst send prio req0_ready", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    step();
    mid();
    chk("rst recover cnt0", 32'(cnt0), 32'd1);
    chk("rst recover cnt1", 32'(cnt1), 32'd0);
    step();

    // Counter saturation on requester 1.
    do_reset();
    set_key(9);
    out_ready = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 800; i++) begin
      req1_data = codeword_t'($urandom);
      step();
    end
    req1_valid = 1'b0;
    step();
    step();
    step();
    step();
    mid();
    chk("sat cnt1", 32'(cnt1), 32'd255);
    chk("sat cnt0", 32'(cnt0), 32'd0);
    step();

    // Randomised traffic against the transaction-level model.
    do_reset();
    m_pending = 0;
    m_age = 0;
    m_last = 1;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_ch_in = '0;
    m_src = 0;
    m_exp_data = '0;
    m_exp_mask = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit v0, v1, e_any, e_g, e_ov;
      v0 = ($urandom_range(0, 99) < 50);
      v1 = ($urandom_range(0, 99) < 50);
      req0_valid = v0;
      req1_valid = v1;
      req0_data = codeword_t'($urandom);
      req1_data = codeword_t'($urandom);
      out_ready = ($urandom_range(0, 99) < 65);
      if (!m_pending) set_key(int'($urandom_range(0, 12)));
      mid();
      e_any = !m_pending && (v0 || v1);
      e_g = (v0 && v1) ? !m_last : v1;
      e_ov = m_pending && (m_age >= 1);
      chk("rnd req0_ready", 32'(req0_ready), 32'(e_any && !e_g));
      chk("rnd req1_ready", 32'(req1_ready), 32'(e_any && e_g));
      chk("rnd busy", 32'(busy), 32'(m_pending));
      chk("rnd out_valid", 32'(out_valid), 32'(e_ov));
      chk("rnd ch_in", 32'(ch_in), 32'(m_ch_in));
      chk("rnd cnt0", 32'(cnt0), 32'(m_cnt[0]));
      chk("rnd cnt1", 32'(cnt1), 32'(m_cnt[1]));
      if (e_ov) begin
        chk("rnd out_data", 32'(out_data), 32'(m_exp_data));
        chk("rnd out_src", 32'(out_src), 32'(m_src));
        chk("rnd out_err_mask", 32'(out_err_mask), 32'(m_exp_mask));
      end
      if (!m_pending) begin
        if (e_any) begin
          m_pending = 1;
          m_age = 0;
          m_src = e_g;
          m_last = e_g;
          m_ch_in = e_g ? req1_data : req0_data;
          m_exp_mask = chan_mask;
          m_exp_data = m_ch_in ^ chan_mask;
        end
      end else if (m_age >= 1 && out_ready) begin
        if (m_cnt[m_src] < 255) m_cnt[m_src]++;
        m_pending = 0;
      end else begin
        m_age = 1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
